// File: rtl/usub_rr_arbiter.sv
// Round-robin share of one saturating-subtract datapath across NUM_REQ requesters; grant->rsp_valid 2 cycles.
// One operation in flight; a stalled response blocks all grants until rsp_ready, so at best 1 op per 3 cycles.

module usub #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] underflow,
  output logic                  sig_uf
);

  logic [DATA_WIDTH:0] diff;

  // The extra top bit of the widened difference is the borrow.
  always_comb begin
    diff      = {1'b0, in0} - {1'b0, in1};
    sig_uf    = diff[DATA_WIDTH];
    out       = '0;
    underflow = '0;
    if (sig_uf) begin
      underflow = in1 - in0;
    end else begin
      out = diff[DATA_WIDTH-1:0];
    end
  end

endmodule

module usub_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_in1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_out,
  output logic [DATA_WIDTH-1:0]         rsp_underflow,
  output logic                          rsp_sig_uf,
  output logic [CNT_WIDTH-1:0]          uf_count,
  input  logic                          uf_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH+1)'(NUM_REQ);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   op0_q, op0_d;
  logic [DATA_WIDTH-1:0]   op1_q, op1_d;
  logic [ID_WIDTH-1:0]     tag_q, tag_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_out_q, rsp_out_d;
  logic [DATA_WIDTH-1:0]   rsp_uf_q, rsp_uf_d;
  logic                    rsp_sig_q, rsp_sig_d;
  logic [CNT_WIDTH-1:0]    uf_count_q, uf_count_d;

  logic                    gnt_found;
  logic [ID_WIDTH-1:0]     gnt_id;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic [ID_WIDTH:0]       scan_idx;
  logic [ID_WIDTH:0]       ptr_nxt;
  logic [DATA_WIDTH-1:0]   sel_in0;
  logic [DATA_WIDTH-1:0]   sel_in1;

  logic [DATA_WIDTH-1:0]   u_out;
  logic [DATA_WIDTH-1:0]   u_underflow;
  logic                    u_sig_uf;

  usub #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_usub (
    .in0       (op0_q),
    .in1       (op1_q),
    .out       (u_out),
    .underflow (u_underflow),
    .sig_uf    (u_sig_uf)
  );

  // Scan from the farthest offset down so the nearest valid requester to ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      if (scan_idx >= NREQ_W) begin
        scan_idx = scan_idx - NREQ_W;
      end
      if (req_valid[scan_idx[ID_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh  = '0;
    sel_in0 = '0;
    sel_in1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = gnt_found && (gnt_id == ID_WIDTH'(i));
      if (gnt_oh[i]) begin
        sel_in0 = req_in0[i*DATA_WIDTH +: DATA_WIDTH];
        sel_in1 = req_in1[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, gnt_id} + (ID_WIDTH+1)'(1);
    if (ptr_nxt == NREQ_W) begin
      ptr_nxt = '0;
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt_oh : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_uf_d    = rsp_uf_q;
    rsp_sig_d   = rsp_sig_q;
    uf_count_d  = uf_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          op0_d   = sel_in0;
          op1_d   = sel_in1;
          tag_d   = gnt_id;
          ptr_d   = ptr_nxt[ID_WIDTH-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = tag_q;
        rsp_out_d   = u_out;
        rsp_uf_d    = u_underflow;
        rsp_sig_d   = u_sig_uf;
        if (u_sig_uf && (uf_count_q != '1)) begin
          uf_count_d = uf_count_q + CNT_WIDTH'(1);
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (uf_clr) begin
      uf_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_uf_q    <= '0;
      rsp_sig_q   <= 1'b0;
      uf_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_uf_q    <= rsp_uf_d;
      rsp_sig_q   <= rsp_sig_d;
      uf_count_q  <= uf_count_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_out       = rsp_out_q;
  assign rsp_underflow = rsp_uf_q;
  assign rsp_sig_uf    = rsp_sig_q;
  assign uf_count      = uf_count_q;

endmodule

// File: tb/tb_usub_rr_arbiter.sv
// Bench for usub_rr_arbiter: a default instance plus a CNT_WIDTH=2 instance sharing the same stimulus.
module tb_usub_rr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_in0;
  logic [NR*DW-1:0] req_in1;
  logic             rsp_ready;
  logic             uf_clr;

  logic [NR-1:0] req_ready_a, req_ready_b;
  logic          rsp_valid_a, rsp_valid_b;
  logic [1:0]    rsp_id_a, rsp_id_b;
  logic [DW-1:0] rsp_out_a, rsp_out_b;
  logic [DW-1:0] rsp_uf_a, rsp_uf_b;
  logic          rsp_sig_a, rsp_sig_b;
  logic [15:0]   uf_count_a;
  logic [1:0]    uf_count_b;

  usub_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_a), .rsp_out(rsp_out_a), .rsp_underflow(rsp_uf_a), .rsp_sig_uf(rsp_sig_a),
    .uf_count(uf_count_a), .uf_clr(uf_clr)
  );

  usub_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_b), .rsp_out(rsp_out_b), .rsp_underflow(rsp_uf_b), .rsp_sig_uf(rsp_sig_b),
    .uf_count(uf_count_b), .uf_clr(uf_clr)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: next-priority index and unbounded event counts clipped per width.
  int m_ptr  = 0;
  int m_cnt16 = 0;
  int m_cnt2  = 0;

  task automatic model_reset();
    m_ptr   = 0;
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    uf_clr    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full transaction: grant, EXEC, RESP with `stall` cycles of backpressure, then handshake.
  task automatic do_op(input logic [NR-1:0] mask, input logic [NR*DW-1:0] a_vec,
                       input logic [NR*DW-1:0] b_vec, input int stall, input bit clr,
                       output int gid, output logic [DW-1:0] o_out, output logic [DW-1:0] o_uf,
                       output logic o_sig);
    int g;
    int ai, bi, e_out, e_uf;
    bit e_sig;
    logic [NR-1:0] exp_rdy;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && mask[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    end
    if (g < 0) g = 0;
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    ai = int'(a_vec[g*DW +: DW]);
    bi = int'(b_vec[g*DW +: DW]);
    if (ai >= bi) begin
      e_out = ai - bi; e_uf = 0; e_sig = 1'b0;
    end else begin
      e_out = 0; e_uf = bi - ai; e_sig = 1'b1;
    end
    gid = g;

    req_valid = mask; req_in0 = a_vec; req_in1 = b_vec; rsp_ready = 1'b0; uf_clr = 1'b0;
    #1;
    checks++;
    if (req_ready_a !== exp_rdy) begin
      errors++; $display("FAIL grant_ready: got %b expected %b", req_ready_a, exp_rdy);
    end
    m_ptr = (g + 1) % NR;

    @(posedge clk); #1;
    req_in0 = $urandom; req_in1 = $urandom; uf_clr = clr;
    #1;
    checks++;
    if (req_ready_a !== '0 || rsp_valid_a !== 1'b0) begin
      errors++; $display("FAIL exec_quiet: ready %b valid %b expected 0000 0", req_ready_a, rsp_valid_a);
    end

    @(posedge clk); #1;
    uf_clr = 1'b0;
    if (clr) begin
      m_cnt16 = 0; m_cnt2 = 0;
    end else if (e_sig) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    rsp_ready = (stall == 0);
    #1;
    checks++;
    if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'(g) || rsp_out_a !== 8'(e_out) ||
        rsp_uf_a !== 8'(e_uf) || rsp_sig_a !== e_sig) begin
      errors++;
      $display("FAIL rsp_fields: got v%0b id%0d out%0d uf%0d sig%0b expected v1 id%0d out%0d uf%0d sig%0b",
               rsp_valid_a, rsp_id_a, rsp_out_a, rsp_uf_a, rsp_sig_a, g, e_out, e_uf, e_sig);
    end
    checks++;
    if (uf_count_a !== 16'(m_cnt16) || uf_count_b !== 2'(m_cnt2)) begin
      errors++;
      $display("FAIL uf_count: got %0d/%0d expected %0d/%0d", uf_count_a, uf_count_b, m_cnt16, m_cnt2);
    end
    o_out = rsp_out_a; o_uf = rsp_uf_a; o_sig = rsp_sig_a;

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      rsp_ready = (s == stall - 1);
      #1;
      checks++;
      if (rsp_valid_a !== 1'b1 || rsp_id_a !== 2'(g) || rsp_out_a !== 8'(e_out) ||
          rsp_uf_a !== 8'(e_uf) || rsp_sig_a !== e_sig || req_ready_a !== '0) begin
        errors++;
        $display("FAIL stall_hold: got v%0b id%0d out%0d uf%0d rdy%b expected v1 id%0d out%0d uf%0d rdy0000",
                 rsp_valid_a, rsp_id_a, rsp_out_a, rsp_uf_a, req_ready_a, g, e_out, e_uf);
      end
    end

    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid_a !== 1'b0) begin
      errors++; $display("FAIL rsp_drop: got %0b expected 0", rsp_valid_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_in0 = '1; req_in1 = '0; rsp_ready = 1'b1; uf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (req_ready_a !== '0 || rsp_valid_a !== 1'b0 || rsp_id_a !== '0 || rsp_out_a !== '0 ||
        rsp_uf_a !== '0 || rsp_sig_a !== 1'b0 || uf_count_a !== '0 || uf_count_b !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy%b v%0b id%0d out%0d uf%0d sig%0b cnt%0d/%0d expected all 0",
               req_ready_a, rsp_valid_a, rsp_id_a, rsp_out_a, rsp_uf_a, rsp_sig_a, uf_count_a, uf_count_b);
    end
    req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int gid; logic [DW-1:0] o, u; logic sg;
    logic [NR*DW-1:0] a, b;
    a = {$urandom}; b = {$urandom};
    a[1*DW +: DW] = 8'd200; b[1*DW +: DW] = 8'd55;
    do_op(4'b0010, a, b, 0, 1'b0, gid, o, u, sg);
    checks++;
    if (gid != 1 || o !== 8'd145 || u !== 8'd0 || sg !== 1'b0) begin
      errors++; $display("FAIL single: got id%0d out%0d uf%0d sig%0b expected id1 out145 uf0 sig0", gid, o, u, sg);
    end
  endtask

  task automatic test_underflow();
    int gid; logic [DW-1:0] o, u; logic sg;
    logic [NR*DW-1:0] a, b;
    a = '0; b = '0;
    a[0 +: DW] = 8'd10; b[0 +: DW] = 8'd30;
    do_op(4'b0001, a, b, 0, 1'b0, gid, o, u, sg);
    checks++;
    if (o !== 8'd0 || u !== 8'd20 || sg !== 1'b1 || uf_count_a !== 16'd1) begin
      errors++; $display("FAIL underflow_10_30: got out%0d uf%0d sig%0b cnt%0d expected 0 20 1 1", o, u, sg, uf_count_a);
    end
    a[0 +: DW] = 8'd0; b[0 +: DW] = 8'd255;
    do_op(4'b0001, a, b, 0, 1'b0, gid, o, u, sg);
    checks++;
    if (u !== 8'd255 || o !== 8'd0 || sg !== 1'b1) begin
      errors++; $display("FAIL underflow_0_255: got out%0d uf%0d sig%0b expected 0 255 1", o, u, sg);
    end
  endtask

  task automatic test_idle();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready_a !== '0 || rsp_valid_a !== 1'b0) begin
        errors++; $display("FAIL idle: rdy%b v%0b expected 0000 0", req_ready_a, rsp_valid_a);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fairness();
    int gid; logic [DW-1:0] o, u; logic sg;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int n = 0; n < 6; n++) begin
      do_op(4'b1111, {$urandom}, {$urandom}, 0, 1'b0, gid, o, u, sg);
      checks++;
      if (gid != order[n]) begin
        errors++; $display("FAIL fairness_order[%0d]: got %0d expected %0d", n, gid, order[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    int gid; logic [DW-1:0] o, u; logic sg;
    do_op(4'b1111, {$urandom}, {$urandom}, 5, 1'b0, gid, o, u, sg);
    do_op(4'b1111, {$urandom}, {$urandom}, 0, 1'b0, gid, o, u, sg);
  endtask

  task automatic test_saturation();
    int gid; logic [DW-1:0] o, u; logic sg;
    logic [NR*DW-1:0] b;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      b = {$urandom} | 32'h0101_0101;
      do_op(4'($urandom_range(1, 15)), '0, b, 0, 1'b0, gid, o, u, sg);
    end
    checks++;
    if (uf_count_b !== 2'd3 || uf_count_a !== 16'd5) begin
      errors++; $display("FAIL saturate: got %0d/%0d expected 3/5", uf_count_b, uf_count_a);
    end
    do_op(4'b0100, '0, 32'hFFFF_FFFF, 0, 1'b1, gid, o, u, sg);
    checks++;
    if (uf_count_b !== 2'd0 || uf_count_a !== 16'd0) begin
      errors++; $display("FAIL clear_wins: got %0d/%0d expected 0/0", uf_count_b, uf_count_a);
    end
    do_op(4'b0100, '0, 32'hFFFF_FFFF, 0, 1'b0, gid, o, u, sg);
    checks++;
    if (uf_count_b !== 2'd1) begin
      errors++; $display("FAIL count_after_clear: got %0d expected 1", uf_count_b);
    end
  endtask

  task automatic test_reset_mid();
    int gid; logic [DW-1:0] o, u; logic sg;
    do_op(4'b0010, {$urandom}, {$urandom}, 0, 1'b0, gid, o, u, sg);
    req_valid = 4'b0100; req_in0 = '0; req_in1 = '1;
    #1;
    checks++;
    if (req_ready_a !== 4'b0100) begin
      errors++; $display("FAIL mid_grant: got %b expected 0100", req_ready_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rsp_valid_a !== 1'b0 || req_ready_a !== '0 || rsp_id_a !== '0 || rsp_out_a !== '0 ||
          rsp_uf_a !== '0 || rsp_sig_a !== 1'b0 || uf_count_a !== '0) begin
        errors++;
        $display("FAIL mid_reset: v%0b rdy%b id%0d out%0d uf%0d sig%0b cnt%0d expected all 0",
                 rsp_valid_a, req_ready_a, rsp_id_a, rsp_out_a, rsp_uf_a, rsp_sig_a, uf_count_a);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_op(4'b1001, {$urandom}, {$urandom}, 0, 1'b0, gid, o, u, sg);
    checks++;
    if (gid != 0) begin
      errors++; $display("FAIL post_reset_grant: got %0d expected 0", gid);
    end
  endtask

  task automatic test_random();
    int gid; logic [DW-1:0] o, u; logic sg;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) test_idle();
      do_op(4'($urandom_range(1, 15)), {$urandom}, {$urandom}, int'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0), gid, o, u, sg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_underflow();
    test_idle();
    test_fairness();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usub_rr_arbiter.md
Name: usub_rr_arbiter

Overview:
- Shares one `usub` saturating-subtract datapath between NUM_REQ independent requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin scheduler grants one requester at a time, sequences the operation through `usub`, and returns the result tagged with the requester ID on a single valid/ready response channel.
- Keeps a saturating count of underflow events for status readout.

Parameters:
- DATA_WIDTH, 8, operand/result width; passed to the internal `usub` instance.
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- CNT_WIDTH, 16, width of the underflow event counter.
- Derived localparam ID_WIDTH = max(1, $clog2(NUM_REQ)).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_in0  input  NUM_REQ*DATA_WIDTH  minuends, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_in1  input  NUM_REQ*DATA_WIDTH  subtrahends, same packing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_WIDTH  index of the requester this response belongs to.
- rsp_out  output  DATA_WIDTH  in0-in1, or 0 on underflow.
- rsp_underflow  output  DATA_WIDTH  in1-in0 on underflow, else 0.
- rsp_sig_uf  output  1  underflow flag.
- uf_count  output  CNT_WIDTH  number of underflowing operations completed.
- uf_clr  input  1  synchronous clear of uf_count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, priority pointer ptr=0.
  - rsp_valid=0; rsp_id, rsp_out, rsp_underflow, rsp_sig_uf = 0; uf_count=0.
  - req_ready=0 while rst_n is low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first index with req_valid set, searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only; all other req_ready bits are 0.
  - On the edge: capture req_in0/req_in1 slice g into operand registers, store g as the tag, set ptr=(g+1) mod NUM_REQ, go to EXEC.
  - No req_valid set: stay in IDLE, ptr unchanged.
- EXEC:
  - `usub` evaluates combinationally on the operand registers.
  - On the edge: register out/underflow/sig_uf and the tag into the rsp_* outputs, set rsp_valid=1, go to RESP.
  - req_ready is all 0.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - The next grant cannot occur in the same cycle as the response handshake.
  - req_ready is all 0.
- Latency and throughput:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - Maximum throughput is one operation per 3 cycles with rsp_ready tied high.
- Requester rules:
  - Request operands only need to be valid during the handshake cycle.
  - A requester dropping req_valid before it is granted is legal; it simply loses its turn.
- Arithmetic: identical to `usub`, computed in DATA_WIDTH+1 bits.
  - in0 >= in1: out = in0 - in1, underflow = 0, sig_uf = 0.
  - Otherwise: out = 0, underflow = in1 - in0 (mod 2^DATA_WIDTH), sig_uf = 1.
- uf_count:
  - Increments by 1 on the EXEC->RESP edge when the registered sig_uf is 1.
  - Saturates at all-ones; no wrap.
  - uf_clr=1 forces 0 on the next edge. When clear and increment coincide, clear wins.
- Reset mid-operation (any state): the in-flight operation is discarded, no response is issued, and the FSM returns to IDLE with ptr=0.

Test Plan:
- Single requester:
  - Stimulus: req 1 valid with in0=200, in1=55, rsp_ready=1.
  - Required response: req_ready[1] high for one cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_out=145, rsp_underflow=0, rsp_sig_uf=0.
- Underflow:
  - Stimulus: req 0 with in0=10, in1=30.
  - Required response: rsp_out=0, rsp_underflow=20, rsp_sig_uf=1, uf_count 0->1.
  - Stimulus: in0=0, in1=255.
  - Required response: rsp_underflow=255.
- Round-robin fairness:
  - Stimulus: all 4 requesters held valid continuously, rsp_ready=1.
  - Required response: grant order 0,1,2,3,0,1; each rsp_id matches its grant; no requester is granted twice before all others have been granted.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid.
  - Required response: rsp_* stable and req_ready=0 throughout; after rsp_ready=1 for one cycle, rsp_valid drops and the next grant occurs one cycle later.
- Counter saturation and clear (CNT_WIDTH=2):
  - Stimulus: 5 underflowing operations.
  - Required response: uf_count stops at 3.
  - Stimulus: uf_clr asserted in the same cycle as a 6th underflow EXEC->RESP edge.
  - Required response: uf_count=0.
- Reset mid-operation:
  - Stimulus: rst_n asserted in EXEC with requester 2 in flight.
  - Required response: rsp_valid stays 0, all outputs 0; after release with req 3 and req 0 valid, req 0 is granted first (ptr=0).
